// File: rtl/kbd_fifo.sv
// Keyboard key buffer between the PS/2 decoder and the CPU KBD_ASCII read port.
// First-word-fall-through FIFO with a sticky overflow flag and a packed status word.
module kbd_fifo #(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          key_valid,
    input  logic [7:0]    key_ascii,
    input  logic          rd_en,
    input  logic          flush,
    input  logic          clr_ovf,
    output logic [7:0]    rd_data,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic [31:0]   status
);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] rp_q, rp_d;
    logic [AW:0]   count_q, count_d;
    logic          ovf_q, ovf_d;

    logic key_req;
    logic do_pop;
    logic do_push;
    logic drop;

    assign empty = (count_q == '0);
    assign full  = (count_q == (AW+1)'(DEPTH));

    // 8'h00 is the decoder's "no key / break" code and never enters the queue.
    assign key_req = key_valid && (key_ascii != 8'h00);
    assign do_pop  = rd_en && !empty;
    assign do_push = key_req && (!full || do_pop);
    assign drop    = key_req && full && !do_pop;

    // NOTE: every signal gets a default at the top of the block, so no path can infer a latch.
    always_comb begin
        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        if (flush) begin
            wp_d    = '0;
            rp_d    = '0;
            count_d = '0;
        end else begin
            if (do_push) wp_d = wp_q + AW'(1);
            if (do_pop)  rp_d = rp_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // A drop in the same cycle as clr_ovf must leave the flag set.
    always_comb begin
        ovf_d = ovf_q;
        if (drop)         ovf_d = 1'b1;
        else if (clr_ovf) ovf_d = 1'b0;
    end

    // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // NOTE: the storage array has no reset; count gates rd_data, so stale contents are never visible.
    always_ff @(posedge clock) begin
        if (do_push && !flush) mem_q[wp_q] <= key_ascii;
    end

    assign rd_data  = empty ? 8'h00 : mem_q[rp_q];
    assign count    = count_q;
    assign overflow = ovf_q;
    assign status   = {ovf_q, full, empty, 13'b0, 8'(count_q), rd_data};

endmodule

// File: tb/tb_kbd_fifo.sv
// Scoreboard bench for kbd_fifo: stimulus queues expected keys, a negedge
// monitor checks every popped key; directed checks cover flags and status.
module tb_kbd_fifo;

    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);

    logic          clock = 1'b0;
    logic          reset;
    logic          key_valid;
    logic [7:0]    key_ascii;
    logic          rd_en;
    logic          flush;
    logic          clr_ovf;
    logic [7:0]    rd_data;
    logic          empty;
    logic          full;
    logic [AW:0]   count;
    logic          overflow;
    logic [31:0]   status;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] exp_q [$];
    logic [7:0] exp_b;

    kbd_fifo #(.DEPTH(DEPTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .key_valid (key_valid),
        .key_ascii (key_ascii),
        .rd_en     (rd_en),
        .flush     (flush),
        .clr_ovf   (clr_ovf),
        .rd_data   (rd_data),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .overflow  (overflow),
        .status    (status)
    );

    always #5 clock = ~clock;

    // Monitor: every accepted pop presents the head key, which must match the scoreboard.
    always @(negedge clock) begin
        if (reset && rd_en && !empty) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL pop_data: got %h, scoreboard holds no expected key", rd_data);
            end else begin
                exp_b = exp_q.pop_front();
                if (rd_data !== exp_b) begin
                    n_bad++;
                    $display("FAIL pop_data: got %h, expected %h", rd_data, exp_b);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic kv, input logic [7:0] k, input logic rd,
                        input logic fl, input logic co);
        key_valid = kv;
        key_ascii = k;
        rd_en     = rd;
        flush     = fl;
        clr_ovf   = co;
        @(posedge clock);
        #1;
        key_valid = 1'b0;
        key_ascii = 8'h00;
        rd_en     = 1'b0;
        flush     = 1'b0;
        clr_ovf   = 1'b0;
    endtask

    task automatic push(input logic [7:0] k, input logic accepted);
        if (accepted) exp_q.push_back(k);
        step(1'b1, k, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop_n(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        reset     = 1'b0;
        key_valid = 1'b0;
        key_ascii = 8'h00;
        rd_en     = 1'b0;
        flush     = 1'b0;
        clr_ovf   = 1'b0;
        #2;
        check("rst_empty",    32'(empty),    32'd1);
        check("rst_full",     32'(full),     32'd0);
        check("rst_count",    32'(count),    32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_rd_data",  32'(rd_data),  32'h00);
        check("rst_status",   status,        32'h2000_0000);
        @(posedge clock);
        #1;
        reset = 1'b1;

        // Three keys, then three pops.
        push(8'h41, 1'b1);
        push(8'h42, 1'b1);
        push(8'h43, 1'b1);
        check("abc_count",   32'(count),   32'd3);
        check("abc_rd_data", 32'(rd_data), 32'h41);
        check("abc_status",  status,       32'h0000_0341);
        pop_n(3);
        check("abc_empty",   32'(empty),   32'd1);
        check("abc_rd_zero", 32'(rd_data), 32'h00);

        // Fill to DEPTH, then one dropped key.
        for (int i = 0; i < 16; i++) push(8'(8'h61 + i), 1'b1);
        check("fill_full",  32'(full),  32'd1);
        check("fill_count", 32'(count), 32'd16);
        push(8'h71, 1'b0);
        check("drop_full",     32'(full),      32'd1);
        check("drop_count",    32'(count),     32'd16);
        check("drop_overflow", 32'(overflow),  32'd1);
        check("drop_status31", 32'(status[31]), 32'd1);
        pop_n(16);
        check("drain_empty", 32'(empty), 32'd1);
        check("drain_count", 32'(count), 32'd0);

        // Push and pop in the same cycle while full.
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check("clr_overflow", 32'(overflow), 32'd0);
        for (int i = 0; i < 16; i++) push(8'(8'h50 + i), 1'b1);
        exp_q.push_back(8'h7A);
        step(1'b1, 8'h7A, 1'b1, 1'b0, 1'b0);
        check("fullpp_overflow", 32'(overflow), 32'd0);
        check("fullpp_count",    32'(count),    32'd16);
        check("fullpp_rd_data",  32'(rd_data),  32'h51);
        pop_n(16);
        check("fullpp_empty", 32'(empty), 32'd1);

        // Null key and pop while empty.
        step(1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
        check("null_count",   32'(count),   32'd0);
        check("null_empty",   32'(empty),   32'd1);
        check("null_rd_data", 32'(rd_data), 32'h00);
        push(8'h31, 1'b1);
        check("after_null_rd_data", 32'(rd_data), 32'h31);
        check("after_null_count",   32'(count),   32'd1);
        pop_n(1);

        // Push and pop while empty: push wins, count becomes 1.
        exp_q.push_back(8'h32);
        step(1'b1, 8'h32, 1'b1, 1'b0, 1'b0);
        check("emptypp_count",   32'(count),   32'd1);
        check("emptypp_rd_data", 32'(rd_data), 32'h32);
        pop_n(1);

        // 40 push/pop pairs through the pointer wrap.
        push(8'h80, 1'b1);
        for (int i = 0; i < 40; i++) begin
            exp_q.push_back(8'(8'h81 + i));
            step(1'b1, 8'(8'h81 + i), 1'b1, 1'b0, 1'b0);
            check("wrap_count", 32'(count), 32'd1);
        end
        check("wrap_rd_data", 32'(rd_data), 32'hA8);
        pop_n(1);

        // Drop together with clr_ovf, then flush with five entries queued.
        for (int i = 0; i < 16; i++) push(8'(8'hB0 + i), 1'b1);
        push(8'hC0, 1'b0);
        check("ovf_set", 32'(overflow), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check("ovf_clr", 32'(overflow), 32'd0);
        step(1'b1, 8'hC1, 1'b0, 1'b0, 1'b1);
        check("ovf_set_wins", 32'(overflow), 32'd1);
        check("ovf_set_count", 32'(count), 32'd16);
        pop_n(11);
        check("preflush_count",   32'(count),   32'd5);
        check("preflush_rd_data", 32'(rd_data), 32'hBB);
        step(1'b1, 8'hD0, 1'b0, 1'b1, 1'b0);
        exp_q.delete();
        check("flush_count",    32'(count),    32'd0);
        check("flush_empty",    32'(empty),    32'd1);
        check("flush_overflow", 32'(overflow), 32'd1);
        check("flush_rd_data",  32'(rd_data),  32'h00);
        check("flush_status",   status,        32'hA000_0000);

        // Asynchronous reset with seven entries queued.
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) push(8'(8'hE0 + i), 1'b1);
        check("prereset_count", 32'(count), 32'd7);
        #2;
        reset = 1'b0;
        exp_q.delete();
        #1;
        check("async_empty",    32'(empty),    32'd1);
        check("async_count",    32'(count),    32'd0);
        check("async_overflow", 32'(overflow), 32'd0);
        check("async_rd_data",  32'(rd_data),  32'h00);
        check("async_status",   status,        32'h2000_0000);
        @(posedge clock);
        #1;
        reset = 1'b1;
        push(8'h55, 1'b1);
        check("post_reset_rd_data", 32'(rd_data), 32'h55);
        check("post_reset_count",   32'(count),   32'd1);
        pop_n(1);
        check("post_reset_empty", 32'(empty), 32'd1);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/kbd_fifo.md
# kbd_fifo

Keyboard input buffer between the PS/2 keyboard decoder and the CPU's memory-mapped `KBD_ASCII` read port. Each decoded ASCII key event from the decoder is queued, so keystrokes that arrive faster than the program polls are not lost. The CPU sees the oldest queued key plus status flags, and each CPU read of the `KBD_ASCII` address consumes exactly one key. Overflow is reported through a sticky flag rather than dropped silently.

## Interface
- `DEPTH`, 16, number of entries; must be a power of 2 and at least 2.
- `AW`, $clog2(DEPTH), pointer width; derived, not overridden.
- `clock` in 1: single clock; the CPU bus clock domain.
- `reset` in 1: asynchronous, active-low reset.
- `key_valid` in 1: one-cycle strobe from the keyboard decoder; the key on `key_ascii` is valid this cycle.
- `key_ascii` in 8: decoded ASCII code of the key.
- `rd_en` in 1: one-cycle pop strobe, asserted when the CPU read of the `KBD_ASCII` address completes.
- `flush` in 1: synchronous clear of all queued entries.
- `clr_ovf` in 1: synchronous clear of the `overflow` flag.
- `rd_data` out 8: head entry; 8'h00 when the FIFO is empty.
- `empty` out 1: FIFO holds no entries.
- `full` out 1: FIFO holds `DEPTH` entries.
- `count` out AW+1: number of entries held, 0..DEPTH.
- `overflow` out 1: sticky flag; a key was dropped because the FIFO was full.
- `status` out 32: packed status word {overflow, full, empty, 13'b0, count zero-extended to 8 bits, rd_data}.

## Operation
- Storage: `DEPTH` x 8 register array with write pointer `wp` and read pointer `rp`, both AW bits wide and wrapping modulo `DEPTH`. `count` is a separate AW+1-bit register.
- Storage is not reset. Only the pointers, `count` and the flags reset.
- Push condition: `key_valid && key_ascii != 8'h00 && (!full || pop)`.
  - A key of 8'h00 is the decoder's "no key / break" code and is ignored.
- Pop condition: `rd_en && !empty`. `rd_en` while empty has no effect.
- Simultaneous push and pop:
  - Not full, not empty: both happen and `count` is unchanged.
  - Full: the pop frees a slot, so the push is accepted, `count` stays at `DEPTH`, and `overflow` is not set.
  - Empty: the push is accepted and the pop is ignored; `count` becomes 1.
- Dropped key: `key_valid` with a nonzero key while full and with no pop.
  - The key is discarded and `overflow` is set.
- `overflow` stays set until `clr_ovf` or reset. If a new drop and `clr_ovf` occur in the same cycle, the set wins.
- `flush`:
  - Sets `wp`, `rp` and `count` to 0 and drops any push or pop in the same cycle.
  - Does not change `overflow`.
- `full` and `empty` are decoded combinationally from `count` (`full` when `count == DEPTH`, `empty` when `count == 0`).
- `rd_data` is first-word-fall-through: `mem[rp]` when not empty, otherwise 8'h00.

## Timing
- Reset asserted (asynchronous, active-low): `wp`, `rp` and `count` are 0. Outputs are `empty`=1, `full`=0, `count`=0, `overflow`=0, `rd_data`=8'h00, `status`=32'h2000_0000.
- Release of reset takes effect on the next rising edge of `clock`.
- Reset asserted mid-operation discards all queued entries immediately, without waiting for a clock edge.
- Push latency: a push sampled at edge N is visible on `rd_data`, `count` and `empty` after edge N, i.e. in cycle N+1.
- Pop latency:
  - The CPU samples `rd_data` while `rd_en` is high.
  - After that edge, `rd_data` shows the next entry, or 8'h00 if the FIFO is now empty.
- Throughput: one push and one pop per cycle.
- Pointer wrap: `wp` and `rp` go from `DEPTH-1` to 0 with no bubble cycle.
- Back-to-back `rd_en` on consecutive cycles pops consecutive entries.

## Test plan
- After reset, push 'A'(8'h41), 'B', 'C' on consecutive cycles -> count=3, rd_data=8'h41; three `rd_en` pulses return 41, 42, 43; then empty=1 and rd_data=00.
- Push 16 keys 8'h61..8'h70, then push 8'h71 -> full=1, count=16, overflow=1, status[31]=1. Pop all 16 -> data returns 61..70 in order and 8'h71 is absent.
- With the FIFO full, push 8'h7A and pop in the same cycle -> overflow stays 0, count=16, and after 16 pops the last value is 7A.
- Push 8'h00 and pulse `rd_en` while empty -> count=0, empty=1, no pointer movement. Follow with push 8'h31 -> rd_data=31.
- Run 40 push/pop pairs through DEPTH=16 to exercise pointer wrap -> output order matches input order. Apply `flush` with 5 queued entries -> count=0 and overflow unchanged. Apply `clr_ovf` in the same cycle as a drop -> overflow stays 1.
- Assert reset low asynchronously mid-stream with 7 entries queued -> outputs reach their reset values without a clock edge. After release, the next push appears at rd_data.
